// File: rtl/i2c_axil_init_seq_pkg.sv
// Shared encodings for the table-driven AXI-lite init sequencer.
package i2c_axil_init_seq_pkg;

    // Table entry layout
    localparam int unsigned EntryWidth = 40;
    localparam int unsigned OpMsb      = 39;
    localparam int unsigned OpLsb      = 38;
    localparam int unsigned RsvdMsb    = 37;
    localparam int unsigned RsvdLsb    = 36;
    localparam int unsigned RegMsb     = 35;
    localparam int unsigned RegLsb     = 32;
    localparam int unsigned ArgMsb     = 31;
    localparam int unsigned ArgLsb     = 0;

    // i2c_master_axil register offsets
    localparam logic [3:0] RegStatus   = 4'h0;
    localparam logic [3:0] RegCmd      = 4'h4;
    localparam logic [3:0] RegData     = 4'h8;
    localparam logic [3:0] RegPrescale = 4'hC;

    typedef enum logic [1:0] {
        OpWrite = 2'd0,
        OpPoll  = 2'd1,
        OpDelay = 2'd2,
        OpEnd   = 2'd3
    } op_e;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StWr,
        StWrResp,
        StRdAddr,
        StRdData,
        StDelay,
        StFinish
    } state_e;

    typedef struct packed {
        op_e         op;
        logic [3:0]  reg_addr;
        logic [31:0] arg;
    } entry_t;

    function automatic entry_t unpack_entry(input logic [EntryWidth-1:0] raw);
        entry_t e;
        e.op       = op_e'(raw[OpMsb:OpLsb]);
        e.reg_addr = raw[RegMsb:RegLsb];
        e.arg      = raw[ArgMsb:ArgLsb];
        return e;
    endfunction

endpackage

// File: rtl/i2c_axil_init_seq.sv
// Table-driven AXI-lite master: fetches entries from an external synchronous ROM and
// executes register writes, status polls, delays and end markers in order.
module i2c_axil_init_seq
    import i2c_axil_init_seq_pkg::*;
#(
    parameter int unsigned TBL_ADDR_WIDTH  = 8,
    parameter int unsigned POLL_TIMEOUT    = 65535,
    parameter int unsigned AXIL_ADDR_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [TBL_ADDR_WIDTH-1:0]  err_index,
    output logic [TBL_ADDR_WIDTH-1:0]  tbl_addr,
    input  logic [EntryWidth-1:0]      tbl_data,
    output logic [AXIL_ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]                 m_axil_awprot,
    output logic                       m_axil_awvalid,
    input  logic                       m_axil_awready,
    output logic [31:0]                m_axil_wdata,
    output logic [3:0]                 m_axil_wstrb,
    output logic                       m_axil_wvalid,
    input  logic                       m_axil_wready,
    input  logic [1:0]                 m_axil_bresp,
    input  logic                       m_axil_bvalid,
    output logic                       m_axil_bready,
    output logic [AXIL_ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]                 m_axil_arprot,
    output logic                       m_axil_arvalid,
    input  logic                       m_axil_arready,
    input  logic [31:0]                m_axil_rdata,
    input  logic [1:0]                 m_axil_rresp,
    input  logic                       m_axil_rvalid,
    output logic                       m_axil_rready
);

    state_e                    state_q, state_d;
    entry_t                    entry_q, entry_d, fetched;
    logic [TBL_ADDR_WIDTH-1:0] tbl_addr_q, tbl_addr_d;
    logic [TBL_ADDR_WIDTH-1:0] err_index_q, err_index_d;
    logic [31:0]               poll_cnt_q, poll_cnt_d;
    logic [31:0]               dly_cnt_q, dly_cnt_d;
    logic                      awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                      arvalid_q, arvalid_d, rready_q, rready_d;
    logic                      done_q, done_d, error_q, error_d;
    logic                      do_adv, do_err, aw_open, w_open;
    logic [AXIL_ADDR_WIDTH-1:0] axil_addr;

    // Reserved entry bits and the upper status half never influence behaviour
    logic [17:0] unused_bits;
    assign unused_bits = {tbl_data[RsvdMsb:RsvdLsb], m_axil_rdata[31:16]};

    assign fetched = unpack_entry(tbl_data);

    // Zero-extend (or truncate) the 4-bit register offset onto the bus address width
    always_comb begin
        axil_addr = '0;
        for (int i = 0; i < 4 && i < int'(AXIL_ADDR_WIDTH); i++) begin
            axil_addr[i] = entry_q.reg_addr[i];
        end
    end

    assign m_axil_awaddr  = axil_addr;
    assign m_axil_araddr  = axil_addr;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_wstrb   = 4'hF;
    assign m_axil_wdata   = entry_q.arg;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;
    assign busy           = (state_q != StIdle) && (state_q != StFinish);
    assign done           = done_q;
    assign error          = error_q;
    assign err_index      = err_index_q;
    assign tbl_addr       = tbl_addr_q;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            entry_q     <= '0;
            tbl_addr_q  <= '0;
            err_index_q <= '0;
            poll_cnt_q  <= '0;
            dly_cnt_q   <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            tbl_addr_q  <= tbl_addr_d;
            err_index_q <= err_index_d;
            poll_cnt_q  <= poll_cnt_d;
            dly_cnt_q   <= dly_cnt_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Next-state logic: sequence entries, drive handshakes, detect errors
    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        tbl_addr_d  = tbl_addr_q;
        err_index_d = err_index_q;
        poll_cnt_d  = poll_cnt_q;
        dly_cnt_d   = dly_cnt_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        done_d      = done_q;
        error_d     = error_q;
        do_adv      = 1'b0;
        do_err      = 1'b0;
        aw_open     = awvalid_q & ~m_axil_awready;
        w_open      = wvalid_q & ~m_axil_wready;

        case (state_q)
            StIdle: begin
                if (start) begin
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    tbl_addr_d = '0;
                    state_d    = StFetch;
                end
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                entry_d = fetched;
                case (fetched.op)
                    OpWrite: begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StWr;
                    end
                    OpPoll: begin
                        poll_cnt_d = '0;
                        arvalid_d  = 1'b1;
                        state_d    = StRdAddr;
                    end
                    OpDelay: begin
                        dly_cnt_d = fetched.arg;
                        state_d   = StDelay;
                    end
                    default: begin
                        done_d  = 1'b1;
                        state_d = StFinish;
                    end
                endcase
            end
            StWr: begin
                // AW and W complete independently; wait until neither is still open
                awvalid_d = aw_open;
                wvalid_d  = w_open;
                if (!aw_open && !w_open) begin
                    bready_d = 1'b1;
                    state_d  = StWrResp;
                end
            end
            StWrResp: begin
                if (m_axil_bvalid) begin
                    bready_d = 1'b0;
                    if (m_axil_bresp != 2'b00) do_err = 1'b1;
                    else                       do_adv = 1'b1;
                end
            end
            StRdAddr: begin
                if (m_axil_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRdData;
                end
            end
            StRdData: begin
                if (m_axil_rvalid) begin
                    rready_d = 1'b0;
                    if (m_axil_rresp != 2'b00) begin
                        do_err = 1'b1;
                    end else if ((m_axil_rdata[15:0] & entry_q.arg[15:0]) ==
                                 entry_q.arg[31:16]) begin
                        do_adv = 1'b1;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 32'd1;
                        if (POLL_TIMEOUT != 0 && poll_cnt_d == POLL_TIMEOUT) begin
                            do_err = 1'b1;
                        end else begin
                            arvalid_d = 1'b1;
                            state_d   = StRdAddr;
                        end
                    end
                end
            end
            StDelay: begin
                if (dly_cnt_q == 32'd0) do_adv = 1'b1;
                else                    dly_cnt_d = dly_cnt_q - 32'd1;
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        // Running off the end of the table without an END entry is an error
        if (do_adv) begin
            tbl_addr_d = tbl_addr_q + TBL_ADDR_WIDTH'(1);
            if (&tbl_addr_q) do_err = 1'b1;
            else             state_d = StFetch;
        end
        if (do_err) begin
            err_index_d = tbl_addr_q;
            error_d     = 1'b1;
            state_d     = StFinish;
        end
    end

endmodule

// File: tb/tb_i2c_axil_init_seq.sv
// Directed bench for i2c_axil_init_seq with a behavioural ROM and AXI-lite slave.
module tb_i2c_axil_init_seq;
    import i2c_axil_init_seq_pkg::*;

    localparam int unsigned TAW = 4;
    localparam int unsigned PT  = 5;
    localparam int unsigned AW  = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           busy, done, error;
    logic [TAW-1:0] err_index, tbl_addr;
    logic [39:0]    tbl_data;
    logic [AW-1:0]  awaddr, araddr;
    logic [2:0]     awprot, arprot;
    logic           awvalid, awready, wvalid, wready, bvalid = 1'b0, bready;
    logic [31:0]    wdata, rdata = '0;
    logic [3:0]     wstrb;
    logic [1:0]     bresp = '0, rresp;
    logic           arvalid, arready, rvalid = 1'b0, rready;

    always #5 clk = ~clk;

    i2c_axil_init_seq #(
        .TBL_ADDR_WIDTH (TAW),
        .POLL_TIMEOUT   (PT),
        .AXIL_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
        .err_index(err_index), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
        .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
        .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
        .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
        .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
        .m_axil_rready(rready)
    );

    // Behavioural synchronous ROM
    logic [39:0] rom [16];
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    // Slave configuration and statistics
    int          aw_lat = 0, w_lat = 0, aw_wait = 0, w_wait = 0;
    logic [1:0]  cfg_bresp = 2'b00;
    bit          b_hold = 1'b0;
    bit          aw_got = 1'b0, w_got = 1'b0;
    int          cyc = 0, aw_cyc = 0, start_cyc = 0;
    int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, aw_alone = 0, rd_base = 0;
    logic [AW-1:0] last_awaddr = '0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_wstrb = '0;
    logic [31:0] rd_vals [8];
    int          rd_idx;
    logic        aw_hit, w_hit;

    assign awready = awvalid && (aw_wait >= aw_lat);
    assign wready  = wvalid && (w_wait >= w_lat);
    assign arready = arvalid;
    assign rresp   = 2'b00;
    assign aw_hit  = aw_got | (awvalid & awready);
    assign w_hit   = w_got | (wvalid & wready);
    assign rd_idx  = (ar_hs - rd_base > 7) ? 7 : ar_hs - rd_base;

    // AXI-lite slave: configurable ready latency, one B per AW+W pair, scripted read data
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
        w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
        if (awvalid && awready) begin
            aw_hs       <= aw_hs + 1;
            last_awaddr <= awaddr;
            aw_cyc      <= cyc;
        end
        if (wvalid && wready) begin
            w_hs       <= w_hs + 1;
            last_wdata <= wdata;
            last_wstrb <= wstrb;
        end
        if (!awvalid && wvalid) aw_alone <= aw_alone + 1;
        if (start && !busy) start_cyc <= cyc;
        if (bvalid && bready) begin
            bvalid <= 1'b0;
            b_hs   <= b_hs + 1;
        end else if (aw_hit && w_hit && !bvalid) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            if (!b_hold) begin
                bvalid <= 1'b1;
                bresp  <= cfg_bresp;
            end
        end else begin
            if (awvalid && awready) aw_got <= 1'b1;
            if (wvalid && wready)   w_got  <= 1'b1;
        end
        if (arvalid && arready) begin
            ar_hs  <= ar_hs + 1;
            rvalid <= 1'b1;
            rdata  <= rd_vals[rd_idx];
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] ent(input op_e op, input logic [3:0] a, input logic [31:0] arg);
        return {op, 2'b00, a, arg};
    endfunction

    task automatic load3(input logic [39:0] e0, input logic [39:0] e1, input logic [39:0] e2);
        for (int i = 0; i < 16; i++) rom[i] = ent(OpEnd, 4'h0, 32'h0);
        rom[0] = e0;
        rom[1] = e1;
        rom[2] = e2;
    endtask

    // Pulse start, optionally re-pulse it mid-run, and count cycles until busy falls
    task automatic run_seq(input bit poke, output int n);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
            start = (poke && n == 5);
        end
        start = 1'b0;
        check_eq("run_terminates", busy, 0);
    endtask

    int n, a0, w0, b0, r0, gap;

    initial begin
        for (int i = 0; i < 8; i++) rd_vals[i] = 32'h0;
        load3(ent(OpEnd, 4'h0, 0), ent(OpEnd, 4'h0, 0), ent(OpEnd, 4'h0, 0));

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
        check_eq("rst_flags", {busy, done, error}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_tbl_addr", tbl_addr, 0);
        check_eq("idle_err_index", err_index, 0);
        check_eq("const_prot_strb", {awprot, arprot, wstrb}, 32'h00F);

        // Single prescale write, ready tied high
        load3(ent(OpWrite, RegPrescale, 32'h40), ent(OpEnd, 4'h0, 0), ent(OpEnd, 4'h0, 0));
        a0 = aw_hs; w0 = w_hs; b0 = b_hs;
        run_seq(1'b0, n);
        check_eq("wr_aw_count", aw_hs - a0, 1);
        check_eq("wr_w_count", w_hs - w0, 1);
        check_eq("wr_b_count", b_hs - b0, 1);
        check_eq("wr_awaddr", last_awaddr, 32'hC);
        check_eq("wr_wdata", last_wdata, 32'h40);
        check_eq("wr_wstrb", last_wstrb, 32'hF);
        check_eq("wr_done_error", {done, error}, 32'h2);
        check_eq("wr_latency_le6", n <= 6, 1);

        // W channel lags AW by 3 cycles
        w_lat = 3;
        a0 = aw_alone; w0 = w_hs; b0 = b_hs;
        run_seq(1'b0, n);
        check_eq("lag_aw_dropped_alone", aw_alone - a0 > 0, 1);
        check_eq("lag_w_count", w_hs - w0, 1);
        check_eq("lag_b_count", b_hs - b0, 1);
        check_eq("lag_done", done, 1);
        w_lat = 0;

        // Poll busy bit: three busy reads then idle
        load3(ent(OpPoll, RegStatus, 32'h0000_0001), ent(OpEnd, 4'h0, 0), ent(OpEnd, 4'h0, 0));
        rd_vals[0] = 32'h1; rd_vals[1] = 32'h1; rd_vals[2] = 32'h1;
        rd_base = ar_hs; r0 = ar_hs;
        run_seq(1'b0, n);
        check_eq("poll_ar_count", ar_hs - r0, 4);
        check_eq("poll_done_error", {done, error}, 32'h2);

        // Poll stuck busy: times out after PT reads
        for (int i = 0; i < 8; i++) rd_vals[i] = 32'h1;
        rd_base = ar_hs; r0 = ar_hs;
        run_seq(1'b0, n);
        check_eq("tmo_ar_count", ar_hs - r0, 5);
        check_eq("tmo_done_error", {done, error}, 32'h1);
        check_eq("tmo_err_index", err_index, 0);

        // Delay then write; a start pulse mid-delay must be ignored
        load3(ent(OpDelay, 4'h0, 32'd10), ent(OpWrite, RegCmd, 32'h5), ent(OpEnd, 4'h0, 0));
        a0 = aw_hs;
        run_seq(1'b1, n);
        gap = aw_cyc - start_cyc;
        check_eq("dly_gap_min", gap >= 12, 1);
        check_eq("dly_gap_max", gap <= 20, 1);
        check_eq("dly_aw_count", aw_hs - a0, 1);
        check_eq("dly_awaddr", last_awaddr, 32'h4);
        check_eq("dly_done", done, 1);

        // Slave error response on the write at index 1
        load3(ent(OpDelay, 4'h0, 0), ent(OpWrite, RegData, 32'h12), ent(OpEnd, 4'h0, 0));
        cfg_bresp = 2'b10;
        run_seq(1'b0, n);
        check_eq("bresp_done_error", {done, error}, 32'h1);
        check_eq("bresp_err_index", err_index, 1);
        cfg_bresp = 2'b00;

        // No END in the table: address wraps and flags the last entry
        for (int i = 0; i < 16; i++) rom[i] = ent(OpDelay, 4'h0, 0);
        run_seq(1'b0, n);
        check_eq("wrap_done_error", {done, error}, 32'h1);
        check_eq("wrap_err_index", err_index, 15);
        check_eq("wrap_tbl_addr", tbl_addr, 0);

        // Reset while waiting for B, then a clean restart
        load3(ent(OpWrite, RegPrescale, 32'h40), ent(OpEnd, 4'h0, 0), ent(OpEnd, 4'h0, 0));
        b_hold = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!bready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_reached_wr_resp", bready, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
        check_eq("mid_rst_flags", {busy, done, error}, 0);
        check_eq("mid_rst_err_index", err_index, 0);
        check_eq("mid_rst_tbl_addr", tbl_addr, 0);
        rst_n = 1'b1;
        b_hold = 1'b0;
        a0 = aw_hs; b0 = b_hs;
        run_seq(1'b0, n);
        check_eq("restart_aw_count", aw_hs - a0, 1);
        check_eq("restart_b_count", b_hs - b0, 1);
        check_eq("restart_awaddr", last_awaddr, 32'hC);
        check_eq("restart_done_error", {done, error}, 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
